// File: rtl/pcm_stream_pkg.sv
// Shared audio constants: sample format, tick divider, FIFO depth and register map for the PCM block.
// Also used by synth_interface.
package pcm_stream_pkg;

  localparam int PCM_BITDEPTH        = 14;
  localparam int PCM_SAMPLECLOCK_DIV = 8;
  localparam int PCM_FIFO_DEPTH      = 64;

  localparam logic [3:0] REG_DATA   = 4'd0;
  localparam logic [3:0] REG_CTRL   = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd2;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_FLUSH_BIT      = 1;
  localparam int STATUS_UNDERRUN_BIT = 10;
  localparam int STATUS_OVERFLOW_BIT = 11;

  typedef struct packed {
    logic [18:0] rsvd;
    logic        enable;
    logic        overflow;
    logic        underrun;
    logic        full;
    logic        empty;
    logic [7:0]  count;
  } status_t;

  function automatic logic [31:0] pack_status(input logic [7:0] count, input logic empty,
                                              input logic full, input logic underrun,
                                              input logic overflow, input logic enable);
    status_t s;
    s          = '0;
    s.count    = count;
    s.empty    = empty;
    s.full     = full;
    s.underrun = underrun;
    s.overflow = overflow;
    s.enable   = enable;
    return s;
  endfunction

endpackage

// File: rtl/pcm_stream_fifo.sv
// pcm_fifo: single-clock sample FIFO, combinational head read, flush beats push/pop.
// Latency: push visible at head next cycle; backpressure: caller must not push when full without a pop.
module pcm_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pcm_stream.sv
// pcm_stream: CPU-fed PCM FIFO played out one sample per 2**SAMPLECLOCK_DIV clocks; PCM_STREAM_IRQ_EN adds low-water irq.
// Latency: register access completes next cycle; backpressure: pushes to a full FIFO are dropped and flagged.
module pcm_stream
  import pcm_stream_pkg::*;
#(
  parameter int BITDEPTH        = PCM_BITDEPTH,
  parameter int DEPTH           = PCM_FIFO_DEPTH,
  parameter int SAMPLECLOCK_DIV = PCM_SAMPLECLOCK_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          addr,
  input  logic [31:0]         data_in,
  input  logic                wen,
  input  logic                ren,
  output logic [31:0]         data_out,
  output logic                ready,
  output logic [BITDEPTH-1:0] pcm_out,
  output logic                pcm_valid,
  output logic                irq
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SAMPLECLOCK_DIV-1:0] div_cnt;
  logic                       tick;
  logic                       enable;
  logic                       underrun;
  logic                       overflow;
  logic [CW-1:0]              count;
  logic                       full;
  logic                       empty;
  logic [BITDEPTH-1:0]        rdata;
  logic                       wr_data, wr_ctrl, wr_status;
  logic                       flush, pop, push, push_drop, underrun_set;
  logic [31:0]                rd_mux;
  logic                       unused_data;

  assign unused_data = ^data_in[31:BITDEPTH];

  assign tick      = &div_cnt;
  assign wr_data   = wen && (addr == REG_DATA);
  assign wr_ctrl   = wen && (addr == REG_CTRL);
  assign wr_status = wen && (addr == REG_STATUS);
  assign flush     = wr_ctrl && data_in[CTRL_FLUSH_BIT];

  // A flush swallows a coincident tick's pop so pcm_out keeps its value.
  assign pop          = tick && enable && !empty && !flush;
  assign push         = wr_data && (!full || pop);
  assign push_drop    = wr_data && full && !pop;
  assign underrun_set = tick && enable && empty;

  pcm_fifo #(.WIDTH(BITDEPTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (data_in[BITDEPTH-1:0]),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_CTRL:   rd_mux = {31'd0, enable};
      REG_STATUS: rd_mux = pack_status(8'(count), empty, full, underrun, overflow, enable);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      enable    <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      ready     <= 1'b0;
      data_out  <= '0;
    end else begin
      div_cnt   <= div_cnt + SAMPLECLOCK_DIV'(1);
      pcm_valid <= tick;
      ready     <= wen || ren;
      data_out  <= ren ? rd_mux : 32'd0;
      if (wr_ctrl) enable <= data_in[CTRL_ENABLE_BIT];
      // Setting events take precedence over a software clear in the same cycle.
      if (underrun_set)                                 underrun <= 1'b1;
      else if (wr_status && data_in[STATUS_UNDERRUN_BIT]) underrun <= 1'b0;
      if (push_drop)                                    overflow <= 1'b1;
      else if (wr_status && data_in[STATUS_OVERFLOW_BIT]) overflow <= 1'b0;
      if (!enable)  pcm_out <= '0;
      else if (pop) pcm_out <= rdata;
    end
  end

`ifdef PCM_STREAM_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= enable && (count <= CW'(DEPTH / 2));
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_stream.sv
// Directed bench for pcm_stream: register-map vector table plus timed playback, overflow, flush, irq and reset sequences.
module tb_pcm_stream;
  import pcm_stream_pkg::*;

`ifdef PCM_STREAM_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic        wen;
  logic        ren;
  logic [31:0] data_out;
  logic        ready;
  logic [13:0] pcm_out;
  logic        pcm_valid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pcm_stream dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .wen       (wen),
    .ren       (ren),
    .data_out  (data_out),
    .ready     (ready),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    wen     = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    chk("wr_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    ren  = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    chk("rd_ready", {31'd0, ready}, 32'd1);
    d = data_out;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pcm_valid && n < budget);
    if (!pcm_valid) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: no pcm_valid within %0d clocks", budget);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    vecs[0]  = '{1'b0, REG_STATUS, 32'h0,        32'h0000_0100};
    vecs[1]  = '{1'b0, REG_CTRL,   32'h0,        32'h0};
    vecs[2]  = '{1'b1, REG_DATA,   32'h0100,     32'h0};
    vecs[3]  = '{1'b0, REG_STATUS, 32'h0,        32'h0000_0001};
    vecs[4]  = '{1'b1, REG_DATA,   32'h0001_2345, 32'h0};
    vecs[5]  = '{1'b0, REG_STATUS, 32'h0,        32'h0000_0002};
    vecs[6]  = '{1'b1, 4'h7,       32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 4'h7,       32'h0,        32'h0};
    vecs[8]  = '{1'b0, REG_DATA,   32'h0,        32'h0};
    vecs[9]  = '{1'b0, REG_STATUS, 32'h0,        32'h0000_0002};
    vecs[10] = '{1'b1, REG_CTRL,   32'h2,        32'h0};
    vecs[11] = '{1'b0, REG_STATUS, 32'h0,        32'h0000_0100};
    vecs[12] = '{1'b1, REG_CTRL,   32'h1,        32'h0};
    vecs[13] = '{1'b0, REG_STATUS, 32'h0,        32'h0000_1100};
    vecs[14] = '{1'b0, REG_CTRL,   32'h0,        32'h1};
    vecs[15] = '{1'b1, REG_CTRL,   32'h0,        32'h0};
    vecs[16] = '{1'b0, REG_STATUS, 32'h0,        32'h0000_0100};

    rst = 1'b1; addr = '0; data_in = '0; wen = 1'b0; ren = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pcm_out",   {18'd0, pcm_out}, 32'd0);
    chk("rst_pcm_valid", {31'd0, pcm_valid}, 32'd0);
    chk("rst_ready",     {31'd0, ready}, 32'd0);
    chk("rst_data_out",  data_out, 32'd0);
    chk("rst_irq",       {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Register map, finished well before the first tick.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) cpu_wr(vecs[i].addr, vecs[i].wdata);
      else begin
        cpu_rd(vecs[i].addr, rd);
        chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, ready}, 32'd0);

    // Playback of three samples, then underrun hold.
    cpu_wr(REG_DATA, 32'h0100);
    cpu_wr(REG_DATA, 32'h0200);
    cpu_wr(REG_DATA, 32'h3FFF);
    cpu_wr(REG_CTRL, 32'h1);
    wait_valid(300, n);
    chk("play0", {18'd0, pcm_out}, 32'h0100);
    wait_valid(300, n);
    chk("play1_gap", n, 256);
    chk("play1", {18'd0, pcm_out}, 32'h0200);
    wait_valid(300, n);
    chk("play2_gap", n, 256);
    chk("play2", {18'd0, pcm_out}, 32'h3FFF);
    wait_valid(300, n);
    chk("hold", {18'd0, pcm_out}, 32'h3FFF);
    cpu_rd(REG_STATUS, rd);
    chk("underrun_status", rd, 32'h0000_1500);
    cpu_wr(REG_STATUS, 32'h400);
    cpu_rd(REG_STATUS, rd);
    chk("underrun_clear", rd, 32'h0000_1100);
    cpu_wr(REG_CTRL, 32'h0);
    @(posedge clk); #1;
    chk("disable_zero", {18'd0, pcm_out}, 32'd0);
    wait_valid(300, n);
    chk("disabled_tick", {18'd0, pcm_out}, 32'd0);

    // Overflow: 65 pushes into 64 entries while disabled.
    for (int i = 0; i < 65; i++) cpu_wr(REG_DATA, 32'h1000 + i);
    cpu_rd(REG_STATUS, rd);
    chk("overflow_status", rd, 32'h0000_0A40);
    cpu_wr(REG_STATUS, 32'h800);
    cpu_rd(REG_STATUS, rd);
    chk("overflow_clear", rd, 32'h0000_0240);

    // Full FIFO: push lands on the same edge as a tick pop.
    cpu_wr(REG_CTRL, 32'h1);
    wait_valid(300, n);
    chk("full_pop0", {18'd0, pcm_out}, 32'h1000);
    cpu_wr(REG_DATA, 32'h2000);
    repeat (254) begin @(posedge clk); #1; end
    cpu_wr(REG_DATA, 32'h2001);
    chk("coinc_valid", {31'd0, pcm_valid}, 32'd1);
    chk("coinc_pop", {18'd0, pcm_out}, 32'h1001);
    cpu_rd(REG_STATUS, rd);
    chk("coinc_status", rd, 32'h0000_1240);

    // Flush at count=10 on the same edge as a tick: no pop, FIFO empty.
    cpu_wr(REG_CTRL, 32'h2);
    for (int i = 0; i < 11; i++) cpu_wr(REG_DATA, 32'h0200 + i);
    wait_valid(300, n);
    cpu_wr(REG_CTRL, 32'h1);
    wait_valid(300, n);
    chk("flush_pre_pop", {18'd0, pcm_out}, 32'h0200);
    cpu_rd(REG_STATUS, rd);
    chk("flush_pre_status", rd, 32'h0000_100A);
    repeat (254) begin @(posedge clk); #1; end
    cpu_wr(REG_CTRL, 32'h3);
    chk("flush_valid", {31'd0, pcm_valid}, 32'd1);
    chk("flush_hold", {18'd0, pcm_out}, 32'h0200);
    cpu_rd(REG_STATUS, rd);
    chk("flush_status", rd, 32'h0000_1100);
    cpu_wr(REG_CTRL, 32'h0);

    // Low-water irq: 33 -> 32 entries.
    cpu_wr(REG_CTRL, 32'h2);
    for (int i = 0; i < 33; i++) cpu_wr(REG_DATA, 32'h0300 + i);
    wait_valid(300, n);
    cpu_wr(REG_CTRL, 32'h1);
    chk("irq_at33", {31'd0, irq}, 32'd0);
    wait_valid(300, n);
    chk("irq_tick_gap", n, 255);
    chk("irq_pop", {18'd0, pcm_out}, 32'h0300);
    chk("irq_same_cycle", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});

    // Reset mid-stream at count=20.
    cpu_wr(REG_CTRL, 32'h2);
    for (int i = 0; i < 20; i++) cpu_wr(REG_DATA, 32'h03A0 + i);
    cpu_wr(REG_CTRL, 32'h1);
    cpu_rd(REG_STATUS, rd);
    chk("pre_rst_status", rd, 32'h0000_1014);
    chk("pre_rst_irq", {31'd0, irq}, {31'd0, IRQ_ON});
    rst = 1'b1;
    #1;
    chk("mid_rst_pcm_out",   {18'd0, pcm_out}, 32'd0);
    chk("mid_rst_pcm_valid", {31'd0, pcm_valid}, 32'd0);
    chk("mid_rst_ready",     {31'd0, ready}, 32'd0);
    chk("mid_rst_data_out",  data_out, 32'd0);
    chk("mid_rst_irq",       {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_valid(300, n);
    chk("post_rst_gap", n, 256);
    chk("post_rst_pcm_out", {18'd0, pcm_out}, 32'd0);
    cpu_rd(REG_STATUS, rd);
    chk("post_rst_status", rd, 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
